// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU multiply/divide/remainder engine: op codes,
// one-hot FSM states and the single restoring-divide step.
package xc_malu_pkg;

  localparam logic [2:0] MALU_OP_MUL   = 3'd0;
  localparam logic [2:0] MALU_OP_MULU  = 3'd1;
  localparam logic [2:0] MALU_OP_MULSU = 3'd2;
  localparam logic [2:0] MALU_OP_CLMUL = 3'd3;
  localparam logic [2:0] MALU_OP_DIV   = 3'd4;
  localparam logic [2:0] MALU_OP_DIVU  = 3'd5;
  localparam logic [2:0] MALU_OP_REM   = 3'd6;
  localparam logic [2:0] MALU_OP_REMU  = 3'd7;

  localparam logic [3:0] MDR_ST_IDLE = 4'b0001;
  localparam logic [3:0] MDR_ST_BUSY = 4'b0010;
  localparam logic [3:0] MDR_ST_FIX  = 4'b0100;
  localparam logic [3:0] MDR_ST_DONE = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE = MDR_ST_IDLE,
    S_BUSY = MDR_ST_BUSY,
    S_FIX  = MDR_ST_FIX,
    S_DONE = MDR_ST_DONE
  } mdr_state_e;

  // Widest operand the divide step supports; narrower XLEN is zero-extended.
  localparam int MDR_MAX_XLEN = 64;

  // One restoring step: shift in_bit into the partial remainder, subtract the
  // divisor when it fits. Returns {new_rem, quotient_bit}.
  function automatic logic [MDR_MAX_XLEN:0] step_div(
    input logic [MDR_MAX_XLEN-1:0] rem,
    input logic                    in_bit,
    input logic [MDR_MAX_XLEN-1:0] divisor
  );
    logic [MDR_MAX_XLEN:0] trial;
    logic                  qbit;
    trial = {rem, in_bit};
    qbit  = (trial >= {1'b0, divisor});
    if (qbit) trial = trial - {1'b0, divisor};
    return {trial[MDR_MAX_XLEN-1:0], qbit};
  endfunction

endpackage

// File: rtl/xc_malu_step_p.sv
// Combinational datapath slice: retires STEP multiplier/quotient bits per call,
// MSB first, for shift-add multiply, carry-less multiply or restoring divide.
module xc_malu_step_p
  import xc_malu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   arg_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic              div_i,
  input  logic              clmul_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN-1:0]   quo_o
);

  logic [2*XLEN-1:0]     acc_w;
  logic [2*XLEN-1:0]     addend;
  logic [XLEN-1:0]       quo_w;
  logic [XLEN-1:0]       rem_w;
  logic [MDR_MAX_XLEN:0] sd;
  logic                  mbit;
  logic                  spare_unused;

  always_comb begin
    acc_w        = acc_i;
    quo_w        = quo_i;
    rem_w        = acc_i[XLEN-1:0];
    addend       = '0;
    sd           = '0;
    mbit         = 1'b0;
    spare_unused = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (div_i) begin
        // quo_w starts as the dividend and fills with quotient bits from the right.
        sd    = step_div(MDR_MAX_XLEN'(rem_w), quo_w[XLEN-1], MDR_MAX_XLEN'(arg_i));
        rem_w = sd[XLEN:1];
        quo_w = {quo_w[XLEN-2:0], sd[0]};
        spare_unused = spare_unused | (|(sd >> (XLEN + 1)));
      end else begin
        mbit   = quo_w[XLEN-1];
        quo_w  = quo_w << 1;
        addend = mbit ? {{XLEN{1'b0}}, arg_i} : '0;
        if (clmul_i) acc_w = (acc_w << 1) ^ addend;
        else         acc_w = (acc_w << 1) + addend;
      end
    end
    acc_o = div_i ? {{XLEN{1'b0}}, rem_w} : acc_w;
    quo_o = quo_w;
  end

endmodule

// File: rtl/xc_malu_mdr_p.sv
// Multi-cycle multiply/divide/remainder engine: latches operand magnitudes,
// iterates STEP bits per BUSY cycle, applies the sign in FIX, holds in DONE.
module xc_malu_mdr_p
  import xc_malu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  parameter int CW   = $clog2(XLEN / STEP) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic [XLEN-1:0]   flush_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [2:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] result,
  output logic              busy,
  output logic [3:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid and result hold until that edge.

  localparam logic [CW-1:0] LAST = CW'(XLEN / STEP - 1);

  mdr_state_e        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   arg_q, arg_d;
  logic [XLEN-1:0]   quo_q, quo_d;

  logic              sign1, sign2, dbz;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN-1:0]   step_quo;

  xc_malu_step_p #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .acc_i   (acc_q),
    .arg_i   (arg_q),
    .quo_i   (quo_q),
    .div_i   (op_q[2]),
    .clmul_i (op_q == MALU_OP_CLMUL),
    .acc_o   (step_acc),
    .quo_o   (step_quo)
  );

  always_comb begin
    sign1 = rs1[XLEN-1] && (op == MALU_OP_MUL || op == MALU_OP_MULSU ||
                            op == MALU_OP_DIV || op == MALU_OP_REM);
    sign2 = rs2[XLEN-1] && (op == MALU_OP_MUL || op == MALU_OP_DIV ||
                            op == MALU_OP_REM);
    mag1  = sign1 ? -rs1 : rs1;
    mag2  = sign2 ? -rs2 : rs2;
    dbz   = op[2] && (rs2 == '0);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    arg_d   = arg_q;
    quo_d   = quo_q;
    if (flush) begin
      state_d = S_IDLE;
      count_d = '0;
      acc_d   = {flush_data, flush_data};
      arg_d   = flush_data;
      quo_d   = flush_data;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d    = op;
            count_d = '0;
            acc_d   = '0;
            state_d = S_BUSY;
            if (op[2]) begin
              arg_d = mag2;
              quo_d = mag1;
              // Remainder follows the dividend; quotient follows the sign product.
              neg_d = (op == MALU_OP_REM) ? sign1 : (sign1 ^ sign2);
              if (dbz) begin
                quo_d   = '1;
                acc_d   = {{XLEN{1'b0}}, rs1};
                neg_d   = 1'b0;
                state_d = S_FIX;
              end
            end else begin
              arg_d = mag1;
              quo_d = mag2;
              neg_d = sign1 ^ sign2;
            end
          end
        end
        S_BUSY: begin
          acc_d   = step_acc;
          quo_d   = step_quo;
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = S_FIX;
        end
        S_FIX: begin
          if (op_q == MALU_OP_DIV || op_q == MALU_OP_DIVU) begin
            quo_d = neg_q ? -quo_q : quo_q;
          end else begin
            acc_d = neg_q ? -acc_q : acc_q;
          end
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      arg_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      arg_q   <= arg_d;
      quo_q   <= quo_d;
    end
  end

  always_comb begin
    if (!op_q[2])      result = acc_q;
    else if (!op_q[1]) result = {{XLEN{1'b0}}, quo_q};
    else               result = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY) || (state_q == S_FIX);
  assign dbg_state = state_q;

endmodule
